// File: rtl/simd_vector_mac_mc.sv
// Multi-context SIMD dot-product MAC: per-lane multiply, registered adder tree,
// saturating per-context accumulate, context-tagged results with valid/ready.
module simd_vector_mac_mc #(
    parameter int unsigned NUM_LANES      = 4,
    parameter int unsigned ELEM_W         = 16,
    parameter int unsigned MAX_NUM_ELEM   = 64,
    parameter int unsigned NUM_CTX        = 4,
    parameter int unsigned MUL_STAGES     = 2,
    parameter int unsigned VEC_MAC_DATA_W = 2*ELEM_W + $clog2(MAX_NUM_ELEM),
    parameter int unsigned CTX_W          = (NUM_CTX > 1) ? $clog2(NUM_CTX) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             valid_i,
    output logic                             ready_o,
    input  logic                             start_i,
    input  logic                             last_i,
    input  logic [CTX_W-1:0]                 ctx_i,
    input  logic                             signed_i,
    input  logic [NUM_LANES*ELEM_W-1:0]      A,
    input  logic [NUM_LANES*ELEM_W-1:0]      B,
    output logic                             vector_mac_valid_o,
    input  logic                             ready_i,
    output logic [VEC_MAC_DATA_W-1:0]        vector_mac_data_o,
    output logic [CTX_W-1:0]                 vector_mac_ctx_o,
    output logic                             vector_mac_sat_o
);

    localparam int unsigned LOG_LANES = $clog2(NUM_LANES);
    localparam int unsigned PROD_W    = 2*ELEM_W + 2;
    localparam int unsigned SUM_W     = PROD_W + LOG_LANES;
    localparam int unsigned DEPTH     = MUL_STAGES + LOG_LANES;
    localparam int unsigned NODES     = 2*NUM_LANES - 1;
    localparam int unsigned ACC_W     = ((VEC_MAC_DATA_W > SUM_W) ? VEC_MAC_DATA_W : SUM_W) + 1;

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'({1'b0, {(VEC_MAC_DATA_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] ACC_MIN = ~ACC_MAX;

    logic signed [ELEM_W:0]         a_ext_c  [NUM_LANES];
    logic signed [ELEM_W:0]         b_ext_c  [NUM_LANES];
    logic signed [PROD_W-1:0]       prod_c   [NUM_LANES];
    logic signed [PROD_W-1:0]       prod_q   [MUL_STAGES][NUM_LANES];
    logic signed [SUM_W-1:0]        tree_c   [NODES];
    logic signed [SUM_W-1:0]        node_q   [NUM_LANES];
    logic [DEPTH-1:0]               vld_q;
    logic [DEPTH-1:0]               start_q;
    logic [DEPTH-1:0]               last_q;
    logic [CTX_W-1:0]               ctx_q    [DEPTH];
    logic signed [VEC_MAC_DATA_W-1:0] acc_q  [NUM_CTX];
    logic [NUM_CTX-1:0]             sat_q;

    logic [CTX_W-1:0]               acc_ctx_c;
    logic signed [VEC_MAC_DATA_W-1:0] acc_base_c;
    logic                           sat_base_c;
    logic signed [ACC_W-1:0]        acc_sum_c;
    logic signed [VEC_MAC_DATA_W-1:0] acc_new_c;
    logic                           clamp_c;
    logic                           sat_new_c;
    logic                           emit_c;

    // Whole pipeline advances unless a held result is being refused downstream
    assign ready_o = !(vector_mac_valid_o && !ready_i);

    // Operand extension by mode and per-lane signed products
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            a_ext_c[l] = {signed_i & A[(l+1)*ELEM_W-1], A[l*ELEM_W +: ELEM_W]};
            b_ext_c[l] = {signed_i & B[(l+1)*ELEM_W-1], B[l*ELEM_W +: ELEM_W]};
            prod_c[l]  = PROD_W'(a_ext_c[l]) * PROD_W'(b_ext_c[l]);
        end
    end

    // Multiplier pipeline registers
    always_ff @(posedge clk) begin
        if (ready_o) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                prod_q[0][l] <= prod_c[l];
            end
            for (int s = 1; s < MUL_STAGES; s++) begin
                for (int l = 0; l < NUM_LANES; l++) begin
                    prod_q[s][l] <= prod_q[s-1][l];
                end
            end
        end
    end

    // Heap-ordered adder tree view: leaves are products, internal nodes are registers
    always_comb begin
        for (int n = 0; n < NODES; n++) begin
            if (n >= NUM_LANES - 1) begin
                tree_c[n] = SUM_W'(prod_q[MUL_STAGES-1][n - (NUM_LANES - 1)]);
            end else begin
                tree_c[n] = node_q[n];
            end
        end
    end

    // One registered level per tree depth; root lands after LOG_LANES cycles
    always_ff @(posedge clk) begin
        if (ready_o) begin
            for (int n = 0; n < NUM_LANES - 1; n++) begin
                node_q[n] <= tree_c[2*n+1] + tree_c[2*n+2];
            end
        end
    end

    // Beat sideband travels alongside the arithmetic
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
        end else if (ready_o) begin
            vld_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    // Sideband payload shift (no reset needed, qualified by vld_q)
    always_ff @(posedge clk) begin
        if (ready_o) begin
            start_q[0] <= start_i;
            last_q[0]  <= last_i;
            ctx_q[0]   <= ctx_i;
            for (int i = 1; i < DEPTH; i++) begin
                start_q[i] <= start_q[i-1];
                last_q[i]  <= last_q[i-1];
                ctx_q[i]   <= ctx_q[i-1];
            end
        end
    end

    // Saturating read-modify-write of the addressed context
    always_comb begin
        acc_ctx_c  = ctx_q[DEPTH-1];
        acc_base_c = '0;
        sat_base_c = 1'b0;
        clamp_c    = 1'b0;
        emit_c     = vld_q[DEPTH-1] && last_q[DEPTH-1];
        if (!start_q[DEPTH-1]) begin
            acc_base_c = acc_q[acc_ctx_c];
            sat_base_c = sat_q[acc_ctx_c];
        end
        acc_sum_c = ACC_W'(acc_base_c) + ACC_W'(tree_c[0]);
        acc_new_c = VEC_MAC_DATA_W'(acc_sum_c);
        if (acc_sum_c > ACC_MAX) begin
            acc_new_c = VEC_MAC_DATA_W'(ACC_MAX);
            clamp_c   = 1'b1;
        end else if (acc_sum_c < ACC_MIN) begin
            acc_new_c = VEC_MAC_DATA_W'(ACC_MIN);
            clamp_c   = 1'b1;
        end
        sat_new_c = sat_base_c | clamp_c;
    end

    // Accumulators, sticky flags and the result register
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CTX; c++) begin
                acc_q[c] <= '0;
            end
            sat_q              <= '0;
            vector_mac_valid_o <= 1'b0;
            vector_mac_data_o  <= '0;
            vector_mac_ctx_o   <= '0;
            vector_mac_sat_o   <= 1'b0;
        end else if (ready_o) begin
            if (vld_q[DEPTH-1]) begin
                acc_q[acc_ctx_c] <= acc_new_c;
                sat_q[acc_ctx_c] <= sat_new_c;
            end
            vector_mac_valid_o <= emit_c;
            if (emit_c) begin
                vector_mac_data_o <= acc_new_c;
                vector_mac_ctx_o  <= acc_ctx_c;
                vector_mac_sat_o  <= sat_new_c;
            end
        end
    end

endmodule

// File: tb/tb_simd_vector_mac_mc.sv
// Self-checking bench for simd_vector_mac_mc: table of single-beat vectors plus
// hand-written multi-beat, saturation, backpressure and reset sequences.
module tb_simd_vector_mac_mc;

    localparam int unsigned NUM_LANES = 4;
    localparam int unsigned ELEM_W    = 16;
    localparam int unsigned CTX_W     = 2;
    localparam int unsigned DW        = 38;
    localparam int unsigned BW        = NUM_LANES*ELEM_W;
    localparam int          LAT       = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_i;
    logic             ready_o;
    logic             start_i;
    logic             last_i;
    logic [CTX_W-1:0] ctx_i;
    logic             signed_i;
    logic [BW-1:0]    A;
    logic [BW-1:0]    B;
    logic             vector_mac_valid_o;
    logic             ready_i;
    logic [DW-1:0]    vector_mac_data_o;
    logic [CTX_W-1:0] vector_mac_ctx_o;
    logic             vector_mac_sat_o;

    simd_vector_mac_mc dut (
        .clk                (clk),
        .rst                (rst),
        .valid_i            (valid_i),
        .ready_o            (ready_o),
        .start_i            (start_i),
        .last_i             (last_i),
        .ctx_i              (ctx_i),
        .signed_i           (signed_i),
        .A                  (A),
        .B                  (B),
        .vector_mac_valid_o (vector_mac_valid_o),
        .ready_i            (ready_i),
        .vector_mac_data_o  (vector_mac_data_o),
        .vector_mac_ctx_o   (vector_mac_ctx_o),
        .vector_mac_sat_o   (vector_mac_sat_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0]    data;
        logic [CTX_W-1:0] ctx;
        logic             sat;
    } exp_t;

    typedef struct {
        logic [CTX_W-1:0] ctx;
        logic             sg;
        logic [BW-1:0]    a;
        logic [BW-1:0]    b;
        longint           exp_data;
        logic             exp_sat;
    } vec_t;

    exp_t sb_q[$];
    vec_t tbl[7];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   acc_cyc = 0;

    localparam logic [BW-1:0] A1234 = {16'd4, 16'd3, 16'd2, 16'd1};
    localparam logic [BW-1:0] B1    = {4{16'd1}};
    localparam logic [BW-1:0] BM1   = {4{16'hFFFF}};
    localparam logic [BW-1:0] AFF   = {4{16'hFFFF}};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic exp_t mk_exp(input longint d, input logic [CTX_W-1:0] c, input logic s);
        exp_t e;
        e.data = DW'(d);
        e.ctx  = c;
        e.sat  = s;
        return e;
    endfunction

    // Scoreboard: compare every handshaken result against the queue head
    always @(negedge clk) begin
        exp_t e;
        if (!rst && vector_mac_valid_o && ready_i) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result: got data 0x%0h ctx %0d, required no result",
                         vector_mac_data_o, vector_mac_ctx_o);
            end else begin
                e = sb_q.pop_front();
                check("result_data", 64'(vector_mac_data_o), 64'(e.data));
                check("result_ctx",  64'(vector_mac_ctx_o),  64'(e.ctx));
                check("result_sat",  64'(vector_mac_sat_o),  64'(e.sat));
            end
        end
    end

    // Drive one beat (caller sits just after a posedge) and wait for acceptance
    task automatic send_beat(input logic st, input logic la, input logic [CTX_W-1:0] c,
                             input logic sg, input logic [BW-1:0] a, input logic [BW-1:0] b,
                             input logic push, input exp_t e);
        int guard = 0;
        valid_i  = 1'b1;
        start_i  = st;
        last_i   = la;
        ctx_i    = c;
        signed_i = sg;
        A        = a;
        B        = b;
        @(negedge clk);
        while (!ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: ready_o stuck at 0, required 1");
            @(posedge clk);
            #1 valid_i = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        if (push) sb_q.push_back(e);
        #1 valid_i = 1'b0;
    endtask

    // Wait until every expected result has been delivered
    task automatic wait_drain();
        int guard = 0;
        while ((sb_q.size() != 0 || vector_mac_valid_o) && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (sb_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int guard;
        int lat;
        logic [CTX_W-1:0] c;

        tbl[0] = '{2'd3, 1'b0, AFF, AFF, 64'sd17179344900, 1'b0};
        tbl[1] = '{2'd3, 1'b1, AFF, AFF, 64'sd4, 1'b0};
        tbl[2] = '{2'd1, 1'b1, {4{16'h8000}}, {4{16'h8000}}, 64'sd4294967296, 1'b0};
        tbl[3] = '{2'd0, 1'b1, {4{16'h8000}}, {4{16'h7FFF}}, -64'sd4294836224, 1'b0};
        tbl[4] = '{2'd2, 1'b0, A1234, {16'd8, 16'd7, 16'd6, 16'd5}, 64'sd70, 1'b0};
        tbl[5] = '{2'd1, 1'b1, {16'd10, 16'd0, 16'd3, 16'hFFFE},
                   {16'd2, 16'd100, 16'hFFFF, 16'd7}, 64'sd3, 1'b0};
        tbl[6] = '{2'd0, 1'b0, {16'd0, 16'd0, 16'd0, 16'hFFFF},
                   {16'd0, 16'd0, 16'd0, 16'd2}, 64'sd131070, 1'b0};

        rst = 1'b1; valid_i = 1'b0; start_i = 1'b0; last_i = 1'b0; ctx_i = '0;
        signed_i = 1'b0; A = '0; B = '0; ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        check("reset_valid", 64'(vector_mac_valid_o), 64'd0);
        check("reset_data",  64'(vector_mac_data_o),  64'd0);
        check("reset_ctx",   64'(vector_mac_ctx_o),   64'd0);
        check("reset_sat",   64'(vector_mac_sat_o),   64'd0);
        check("reset_ready", 64'(ready_o),            64'd1);

        // Signed single context, four beats, latency measured on the last beat
        for (int k = 0; k < 4; k++) begin
            send_beat(k == 0, k == 3, 2'd0, 1'b1, A1234, B1, k == 3, mk_exp(40, 2'd0, 1'b0));
        end
        guard = 0;
        while (!vector_mac_valid_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        lat = cyc - acc_cyc;
        check("last_beat_latency", 64'(lat), 64'(LAT));
        wait_drain();

        // Interleaved contexts 0 and 1
        for (int k = 0; k < 8; k++) begin
            c = CTX_W'(k % 2);
            send_beat(k < 2, k >= 6, c, 1'b1, A1234, (c != 0) ? BM1 : B1, k >= 6,
                      mk_exp((c != 0) ? -40 : 40, c, 1'b0));
        end
        wait_drain();

        // Table of single-beat vectors streamed back to back
        for (int i = 0; i < 7; i++) begin
            send_beat(1'b1, 1'b1, tbl[i].ctx, tbl[i].sg, tbl[i].a, tbl[i].b, 1'b1,
                      mk_exp(tbl[i].exp_data, tbl[i].ctx, tbl[i].exp_sat));
        end
        wait_drain();

        // Saturation on ctx2, then a fresh vector clears the sticky flag
        for (int k = 0; k < 64; k++) begin
            send_beat(k == 0, k == 63, 2'd2, 1'b0, AFF, AFF, k == 63,
                      mk_exp(64'sd137438953471, 2'd2, 1'b1));
        end
        send_beat(1'b1, 1'b1, 2'd2, 1'b0, A1234, B1, 1'b1, mk_exp(10, 2'd2, 1'b0));
        wait_drain();

        // Backpressure: refuse results for ten cycles once the first is valid
        ready_i = 1'b0;
        send_beat(1'b1, 1'b1, 2'd1, 1'b1, BW'(5), BW'(1), 1'b1, mk_exp(5, 2'd1, 1'b0));
        send_beat(1'b1, 1'b1, 2'd2, 1'b1, BW'(6), BW'(1), 1'b1, mk_exp(6, 2'd2, 1'b0));
        send_beat(1'b1, 1'b1, 2'd3, 1'b1, BW'(7), BW'(1), 1'b1, mk_exp(7, 2'd3, 1'b0));
        guard = 0;
        while (!vector_mac_valid_o && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("stall_first_valid", 64'(vector_mac_valid_o), 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("stall_ready_low", 64'(ready_o), 64'd0);
            check("stall_data_held", 64'(vector_mac_data_o), 64'd5);
            @(posedge clk);
            #1;
        end
        ready_i = 1'b1;
        wait_drain();

        // Reset in the middle of a vector on ctx0
        send_beat(1'b1, 1'b0, 2'd0, 1'b1, A1234, B1, 1'b0, mk_exp(0, 2'd0, 1'b0));
        send_beat(1'b0, 1'b0, 2'd0, 1'b1, A1234, B1, 1'b0, mk_exp(0, 2'd0, 1'b0));
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midreset_valid", 64'(vector_mac_valid_o), 64'd0);
        check("midreset_data",  64'(vector_mac_data_o),  64'd0);
        check("midreset_ready", 64'(ready_o),            64'd1);
        send_beat(1'b0, 1'b1, 2'd0, 1'b1, A1234, B1, 1'b1, mk_exp(10, 2'd0, 1'b0));
        wait_drain();
        repeat (10) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
